// File: rtl/bram_uart_reader.sv
// bram_uart_reader: replays a BRAM byte range into the byte-wide UART transmitter
// through its data/we/wait handshake. Each byte costs READ, LATCH and SEND cycles.
// Optional build macro BRAM_UART_READER_CHECKSUM_EN appends a two's-complement
// checksum byte, so the mod-256 sum of all sent bytes is zero.
module bram_uart_reader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_we,
    input  logic              tx_wait
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
`ifdef BRAM_UART_READER_CHECKSUM_EN
        , S_CSUM = 3'd5
`endif
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [DATA_W-1:0] w_tx_data_next;
    logic              w_tx_accept;
`ifdef BRAM_UART_READER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] w_sum_next;
`endif

    // Next-state, next address/count and next transmit byte
    always_comb begin
        w_next_state   = r_state;
        w_addr_next    = r_addr;
        w_count_next   = r_count;
        w_tx_data_next = tx_data;
        w_tx_accept    = tx_we && !tx_wait;
`ifdef BRAM_UART_READER_CHECKSUM_EN
        w_sum_next     = r_sum;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_addr_next  = start_addr;
                    w_count_next = length;
`ifdef BRAM_UART_READER_CHECKSUM_EN
                    w_sum_next   = '0;
`endif
                    w_next_state = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ:  w_next_state = S_LATCH;
            S_LATCH: begin
                w_tx_data_next = mem_rd_data;
                w_next_state   = S_SEND;
            end
            S_SEND: begin
                if (w_tx_accept) begin
                    w_addr_next  = r_addr + ADDR_W'(1);
                    w_count_next = r_count - CNT_W'(1);
`ifdef BRAM_UART_READER_CHECKSUM_EN
                    w_sum_next   = r_sum + tx_data;
                    if (r_count == CNT_W'(1)) begin
                        w_tx_data_next = DATA_W'(~w_sum_next + DATA_W'(1));
                        w_next_state   = S_CSUM;
                    end else begin
                        w_next_state   = S_READ;
                    end
`else
                    w_next_state = (r_count == CNT_W'(1)) ? S_DONE : S_READ;
`endif
                end
            end
`ifdef BRAM_UART_READER_CHECKSUM_EN
            S_CSUM: begin
                if (w_tx_accept) begin
                    w_next_state = S_DONE;
                end
            end
`endif
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State and internal counters; outputs registered from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_count   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            tx_data   <= '0;
            tx_we     <= 1'b0;
`ifdef BRAM_UART_READER_CHECKSUM_EN
            r_sum     <= '0;
`endif
        end else begin
            r_state   <= w_next_state;
            r_addr    <= w_addr_next;
            r_count   <= w_count_next;
            busy      <= (w_next_state != S_IDLE);
            done      <= (w_next_state == S_DONE);
            mem_rd_en <= (w_next_state == S_READ);
            tx_data   <= w_tx_data_next;
`ifdef BRAM_UART_READER_CHECKSUM_EN
            r_sum     <= w_sum_next;
            tx_we     <= (w_next_state == S_SEND) || (w_next_state == S_CSUM);
`else
            tx_we     <= (w_next_state == S_SEND);
`endif
            if (w_next_state == S_READ) begin
                mem_addr <= w_addr_next;
            end
        end
    end

endmodule

// File: tb/tb_bram_uart_reader.sv
// Directed bench for bram_uart_reader with a BRAM model, a UART-like tx_wait
// model and a scoreboard of expected bytes and read addresses.
module tb_bram_uart_reader;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
`ifdef BRAM_UART_READER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic              clk;
    logic              resetn;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_we;
    logic              tx_wait;

    bram_uart_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .tx_data    (tx_data),
        .tx_we      (tx_we),
        .tx_wait    (tx_wait)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [DEPTH];
    logic [7:0] exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    int acc_t [$];

    int  cyc         = 0;
    int  done_cnt    = 0;
    int  busy_cycles = 0;
    int  tx_cnt      = 0;
    int  rd_cnt      = 0;
    int  stall_cnt   = 0;
    bit  uart_mode   = 1'b0;
    int  uart_cnt    = 0;
    bit  prev_stall  = 1'b0;
    logic [7:0] prev_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Synchronous-read BRAM model
    always @(posedge clk) begin
        cyc++;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Transmitter model: busy for 10 bit-times (2 cycles each) after acceptance
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_wait  <= 1'b0;
            uart_cnt <= 0;
        end else if (!uart_mode) begin
            tx_wait <= 1'b0;
        end else if (tx_we && !tx_wait) begin
            tx_wait  <= 1'b1;
            uart_cnt <= 19;
        end else if (uart_cnt != 0) begin
            uart_cnt <= uart_cnt - 1;
        end else begin
            tx_wait <= 1'b0;
        end
    end

    // Monitor on the falling edge: reads, accepted bytes, stall stability
    always @(negedge clk) begin
        if (resetn) begin
            if (done) done_cnt++;
            if (busy) busy_cycles++;
            if (mem_rd_en) begin
                rd_cnt++;
                check("rd_expected", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) check("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            end
            if (tx_we) begin
                if (prev_stall) check("stall_hold", 32'(tx_data), 32'(prev_data));
                if (tx_wait) stall_cnt++;
                if (!tx_wait) begin
                    tx_cnt++;
                    acc_t.push_back(cyc);
                    check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                prev_stall = tx_wait;
                prev_data  = tx_data;
            end else begin
                if (prev_stall) check("stall_we_drop", 32'(tx_we), 32'd1);
                prev_stall = 1'b0;
            end
        end
    end

    task automatic push_xfer(input int a, input int len);
        logic [7:0] sum;
        logic [ADDR_W-1:0] ad;
        sum = '0;
        for (int i = 0; i < len; i++) begin
            ad = ADDR_W'((a + i) % DEPTH);
            addr_q.push_back(ad);
            exp_q.push_back(mem[ad]);
            sum = sum + mem[ad];
        end
        if (CS != 0 && len != 0) exp_q.push_back(8'(~sum + 8'd1));
    endtask

    task automatic pulse_start(input int a, input int len);
        @(negedge clk);
        start      = 1'b1;
        start_addr = ADDR_W'(a);
        length     = (ADDR_W+1)'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        check(tag, 32'(done_cnt - d0), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_tx_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_rd_drained"}, 32'(addr_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0, b0, t0, r0, s0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i) ^ 8'h5A;
        resetn = 1'b0; start = 1'b0; start_addr = '0; length = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_tx_we", 32'(tx_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 1: four bytes from address 0, no stall
        d0 = done_cnt; b0 = busy_cycles; t0 = tx_cnt;
        acc_t.delete();
        push_xfer(0, 4);
        pulse_start(0, 4);
        wait_done(d0, "t1_done");
        check("t1_bytes", 32'(tx_cnt - t0), 32'(4 + CS));
        check("t1_busy_cycles", 32'(busy_cycles - b0), 32'(13 + CS));
        for (int i = 1; i < 4; i++) check("t1_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd3);

        // 2: address wrap 4094 -> 4095 -> 0
        d0 = done_cnt; r0 = rd_cnt;
        push_xfer(4094, 3);
        pulse_start(4094, 3);
        wait_done(d0, "t2_done");
        check("t2_reads", 32'(rd_cnt - r0), 32'd3);

        // 3: UART-paced transmitter stalls
        uart_mode = 1'b1;
        d0 = done_cnt; t0 = tx_cnt; s0 = stall_cnt;
        push_xfer(20, 2);
        pulse_start(20, 2);
        wait_done(d0, "t3_done");
        check("t3_bytes", 32'(tx_cnt - t0), 32'(2 + CS));
        check("t3_stalled", 32'(stall_cnt - s0 > 10), 32'd1);
        uart_mode = 1'b0;
        repeat (25) @(negedge clk);

        // 4a: zero length, done one cycle after start
        d0 = done_cnt; t0 = tx_cnt; r0 = rd_cnt;
        pulse_start(7, 0);
        check("t4_done_now", 32'(done), 32'd1);
        check("t4_busy_now", 32'(busy), 32'd1);
        @(negedge clk);
        check("t4_done_gone", 32'(done), 32'd0);
        check("t4_busy_gone", 32'(busy), 32'd0);
        check("t4_no_tx", 32'(tx_cnt - t0), 32'd0);
        check("t4_no_rd", 32'(rd_cnt - r0), 32'd0);

        // 4b: second start while busy is ignored
        d0 = done_cnt; t0 = tx_cnt;
        push_xfer(10, 5);
        pulse_start(10, 5);
        repeat (3) @(negedge clk);
        start = 1'b1; start_addr = ADDR_W'(100); length = (ADDR_W+1)'(7);
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, "t4b_done");
        repeat (20) @(negedge clk);
        check("t4b_bytes", 32'(tx_cnt - t0), 32'(5 + CS));

        // 5: asynchronous reset in the middle of SEND
        d0 = done_cnt;
        push_xfer(0, 8);
        pulse_start(0, 8);
        for (int i = 0; i < 20 && !tx_we; i++) @(negedge clk);
        check("t5_in_send", 32'(tx_we), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t5_rst_tx_we", 32'(tx_we), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_rd_en", 32'(mem_rd_en), 32'd0);
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_stays_idle", 32'(busy), 32'd0);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        d0 = done_cnt; t0 = tx_cnt;
        push_xfer(0, 1);
        pulse_start(0, 1);
        wait_done(d0, "t5_done");
        check("t5_bytes", 32'(tx_cnt - t0), 32'(1 + CS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
